// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the 3x3 pair-MAC convolution engine.
//   pixel_t / weight_t : signed Q7.8 16-bit samples
//   window_t           : nine pixel_t, row-major, top-left first
//   state_t            : sweep controller states
//   unpack()           : splits a 144-bit window/ROM word into window_t
//                        (element i lives at bits [143-16*i -: 16])
package conv_pkg;

  localparam int KERNEL_TAPS = 9;
  localparam int PIX_W       = 16;
  localparam int PROD_W      = 32;
  localparam int SUM_W       = 36;
  localparam int WORD_W      = KERNEL_TAPS * PIX_W;

  typedef logic signed [PIX_W-1:0] pixel_t;
  typedef logic signed [PIX_W-1:0] weight_t;
  typedef pixel_t window_t [KERNEL_TAPS];

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  // Element 0 sits in the most significant lane.
  function automatic window_t unpack(input logic [WORD_W-1:0] word);
    window_t w;
    for (int i = 0; i < KERNEL_TAPS; i++) begin
      w[i] = word[WORD_W-1-PIX_W*i -: PIX_W];
    end
    return w;
  endfunction

endpackage

// File: rtl/dot9_q.sv
// dot9_q: one lane of the pair MAC. Nine registered signed 16x16 products,
// a 9-input adder tree, arithmetic shift by FRAC_BITS, saturation to 16 bits
// and a registered result.
// Optional build macro: CONV_PAIR_MAC_RELU_EN fuses a ReLU after saturation.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   prod_en     load the product registers (ROM data valid this cycle)
//   out_en      load the result register (products valid this cycle)
//   pix_word    144-bit pixel window
//   wgt_word    144-bit kernel weights
//   result      signed 16-bit result, held while out_en is low
module dot9_q
  import conv_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     prod_en,
  input  logic                     out_en,
  input  logic [WORD_W-1:0]        pix_word,
  input  logic [WORD_W-1:0]        wgt_word,
  output logic signed [PIX_W-1:0]  result
);

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(32767);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-32768);

  window_t                   pix;
  window_t                   wgt;
  logic signed [PROD_W-1:0]  prod [KERNEL_TAPS];
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   shifted;
  logic signed [PIX_W-1:0]   res_next;

  always_comb begin
    pix = unpack(pix_word);
    wgt = unpack(wgt_word);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KERNEL_TAPS; i++) prod[i] <= '0;
    end else if (prod_en) begin
      for (int i = 0; i < KERNEL_TAPS; i++) begin
        prod[i] <= PROD_W'(pix[i]) * PROD_W'(wgt[i]);
      end
    end
  end

  // 36 bits hold nine full-scale products without overflow, so the only
  // clipping happens at the 16-bit saturation step.
  always_comb begin
    sum = '0;
    for (int i = 0; i < KERNEL_TAPS; i++) begin
      sum = sum + SUM_W'(prod[i]);
    end
    shifted = sum >>> FRAC_BITS;
    if (shifted > SAT_MAX) begin
      res_next = 16'sh7FFF;
    end else if (shifted < SAT_MIN) begin
      res_next = -16'sh8000;
    end else begin
      res_next = shifted[PIX_W-1:0];
    end
`ifdef CONV_PAIR_MAC_RELU_EN
    if (res_next[PIX_W-1]) res_next = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (out_en) begin
      result <= res_next;
    end
  end

endmodule

// File: rtl/conv3x3_pair_mac.sv
// conv3x3_pair_mac: for each accepted 3x3 window, sweeps every kernel of a
// dual-port weight ROM two at a time (even kernel on port A, odd on port B)
// and streams saturated Q7.8 dot products, one pair per cycle.
// Optional build macro: CONV_PAIR_MAC_RELU_EN (fused ReLU in both lanes).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   win_valid/win_ready   window handshake; ready only while idle
//   win_data              nine signed 16-bit pixels
//   rom_addr_a/b          registered ROM addresses 2k / 2k+1
//   rom_q_a/b             ROM data, one cycle after the address
//   out_valid             result pair valid
//   out_kidx              kernel index of out_a (out_b is out_kidx+1)
//   out_a/out_b           signed 16-bit results
//   done                  pulses with the last pair of a window
// Latency: window accepted in cycle T, pair k appears in cycle T+4+k.
module conv3x3_pair_mac
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 144,
  parameter int NUM_KERNELS = 76,
  parameter int FRAC_BITS   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   win_valid,
  output logic                   win_ready,
  input  logic [DATA_WIDTH-1:0]  win_data,
  output logic [ADDR_WIDTH-1:0]  rom_addr_a,
  output logic [ADDR_WIDTH-1:0]  rom_addr_b,
  input  logic [DATA_WIDTH-1:0]  rom_q_a,
  input  logic [DATA_WIDTH-1:0]  rom_q_b,
  output logic                   out_valid,
  output logic [ADDR_WIDTH-1:0]  out_kidx,
  output logic signed [15:0]     out_a,
  output logic signed [15:0]     out_b,
  output logic                   done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_KERNELS - 2);

  state_t                  state;
  state_t                  next_state;
  logic [1:0]              drain_cnt;
  logic [DATA_WIDTH-1:0]   win_reg;
  logic                    issue_last;

  logic                    s1_valid;
  logic                    s1_last;
  logic [ADDR_WIDTH-1:0]   s1_kidx;
  logic                    s2_valid;
  logic                    s2_last;
  logic [ADDR_WIDTH-1:0]   s2_kidx;

  // rom_addr_a doubles as the pair counter: it reads 2k while pair k issues.
  assign issue_last = (rom_addr_a == LAST_ADDR);
  assign win_ready  = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (win_valid)        next_state = FETCH;
      FETCH:   if (issue_last)       next_state = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Window capture, address generation and drain timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_reg    <= '0;
      rom_addr_a <= '0;
      rom_addr_b <= '0;
      drain_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_valid) begin
            win_reg    <= win_data;
            rom_addr_a <= '0;
            rom_addr_b <= ADDR_WIDTH'(1);
          end
        end
        FETCH: begin
          drain_cnt <= '0;
          if (!issue_last) begin
            rom_addr_a <= rom_addr_a + ADDR_WIDTH'(2);
            rom_addr_b <= rom_addr_b + ADDR_WIDTH'(2);
          end
        end
        DRAIN: drain_cnt <= drain_cnt + 2'd1;
        default: drain_cnt <= '0;
      endcase
    end
  end

  // Valid/index/last tags travel alongside the data: stage 1 is ROM return,
  // stage 2 the product registers, stage 3 the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_kidx   <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_kidx   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_kidx  <= '0;
    end else begin
      s1_valid  <= (state == FETCH);
      s1_last   <= (state == FETCH) && issue_last;
      s1_kidx   <= rom_addr_a;
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      s2_kidx   <= s1_kidx;
      out_valid <= s2_valid;
      done      <= s2_valid && s2_last;
      if (s2_valid) out_kidx <= s2_kidx;
    end
  end

  dot9_q #(.FRAC_BITS(FRAC_BITS)) u_lane_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .prod_en  (s1_valid),
    .out_en   (s2_valid),
    .pix_word (win_reg),
    .wgt_word (rom_q_a),
    .result   (out_a)
  );

  dot9_q #(.FRAC_BITS(FRAC_BITS)) u_lane_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .prod_en  (s1_valid),
    .out_en   (s2_valid),
    .pix_word (win_reg),
    .wgt_word (rom_q_b),
    .result   (out_b)
  );

endmodule

// File: tb/tb_conv3x3_pair_mac.sv
// tb_conv3x3_pair_mac: randomized self-checking bench for conv3x3_pair_mac.
// A behavioural ROM feeds the DUT; expected results come from a plain
// integer dot-product model evaluated per kernel for every output cycle.
// Honours CONV_PAIR_MAC_RELU_EN in its model when the DUT is built with it.
module tb_conv3x3_pair_mac;

  localparam int AW    = 7;
  localparam int DW    = 144;
  localparam int NK    = 76;
  localparam int NPAIR = NK / 2;
  localparam int SWEEP = NPAIR + 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           win_valid = 1'b0;
  logic [DW-1:0]  win_data = '0;
  logic           win_ready;
  logic [AW-1:0]  rom_addr_a;
  logic [AW-1:0]  rom_addr_b;
  logic [DW-1:0]  rom_q_a;
  logic [DW-1:0]  rom_q_b;
  logic           out_valid;
  logic [AW-1:0]  out_kidx;
  logic [15:0]    out_a;
  logic [15:0]    out_b;
  logic           done;

  logic [DW-1:0]  rom [NK];
  int             checkCount = 0;
  int             failCount = 0;
  logic [15:0]    firstA;
  logic [15:0]    firstB;

  conv3x3_pair_mac dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .rom_addr_a (rom_addr_a),
    .rom_addr_b (rom_addr_b),
    .rom_q_a    (rom_q_a),
    .rom_q_b    (rom_q_b),
    .out_valid  (out_valid),
    .out_kidx   (out_kidx),
    .out_a      (out_a),
    .out_b      (out_b),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Registered-read ROM, one cycle of latency on each port.
  always @(posedge clk) begin
    rom_q_a <= (int'(rom_addr_a) < NK) ? rom[rom_addr_a] : '0;
    rom_q_b <= (int'(rom_addr_b) < NK) ? rom[rom_addr_b] : '0;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand144();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // Reference: exact integer dot product, floor-divide by 2^8, clip.
  function automatic logic [15:0] refDot(input logic [DW-1:0] win, input logic [DW-1:0] kern);
    longint acc;
    longint r;
    logic [15:0] p;
    logic [15:0] w;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      p = win[DW-1-16*i -: 16];
      w = kern[DW-1-16*i -: 16];
      acc += longint'($signed(p)) * longint'($signed(w));
    end
    r = acc >>> 8;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`ifdef CONV_PAIR_MAC_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[15:0];
  endfunction

  // Expected behaviour in local cycle lc (1..SWEEP) after the window's accept.
  task automatic checkCycle(input logic [DW-1:0] w, input int lc);
    logic [AW-1:0] k;
    bit            valid;
    checkOutput("win_ready", 32'(win_ready), 32'(lc == SWEEP));
    k = (lc <= NPAIR) ? AW'(2 * (lc - 1)) : AW'(NK - 2);
    checkOutput("rom_addr_a", 32'(rom_addr_a), 32'(k));
    checkOutput("rom_addr_b", 32'(rom_addr_b), 32'(k) + 1);
    valid = (lc >= 4) && (lc <= NPAIR + 3);
    checkOutput("out_valid", 32'(out_valid), 32'(valid));
    checkOutput("done", 32'(done), 32'(lc == NPAIR + 3));
    if (lc >= 4) begin
      k = valid ? AW'(2 * (lc - 4)) : AW'(NK - 2);
      checkOutput("out_kidx", 32'(out_kidx), 32'(k));
      checkOutput("out_a", 32'(out_a), 32'(refDot(w, rom[k])));
      checkOutput("out_b", 32'(out_b), 32'(refDot(w, rom[int'(k) + 1])));
      if (lc == 4) begin
        firstA = out_a;
        firstB = out_b;
      end
    end
  endtask

  // Offers win1; with keepValid the handshake stays high and win2 follows
  // back-to-back. abortAt > 0 pulls reset in that local cycle.
  task automatic applyStimulus(input logic [DW-1:0] win1, input logic [DW-1:0] win2,
                               input bit keepValid, input int abortAt);
    int waitCycles;
    int lastC;
    @(negedge clk);
    win_data  = win1;
    win_valid = 1'b1;
    waitCycles = 0;
    while (!win_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!win_ready) begin
      checkOutput("ready_timeout", 32'(win_ready), 32'd1);
      win_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (keepValid) win_data = win2;
    else           win_valid = 1'b0;
    lastC = keepValid ? 2 * SWEEP : SWEEP;
    for (int c = 1; c <= lastC; c++) begin
      @(negedge clk);
      if (c == abortAt) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_addr_a", 32'(rom_addr_a), 32'd0);
        checkOutput("abort_addr_b", 32'(rom_addr_b), 32'd0);
        checkOutput("abort_ready", 32'(win_ready), 32'd1);
        win_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (c == SWEEP + 1) win_valid = 1'b0;
      if (c > SWEEP) checkCycle(win2, c - SWEEP);
      else           checkCycle(win1, c);
    end
  endtask

  initial begin
    logic [DW-1:0] w1;
    logic [DW-1:0] w2;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(win_ready), 32'd1);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_addr_a", 32'(rom_addr_a), 32'd0);
    checkOutput("rst_addr_b", 32'(rom_addr_b), 32'd0);
    checkOutput("rst_out_a", 32'(out_a), 32'd0);
    checkOutput("rst_kidx", 32'(out_kidx), 32'd0);
    rst_n = 1'b1;

    // Unity / negation
    for (int n = 0; n < NK; n++) rom[n] = rand144();
    rom[0] = {9{16'h0100}};
    rom[1] = {9{16'hFF00}};
    applyStimulus({9{16'h0100}}, '0, 1'b0, 0);
    checkOutput("unity_a", 32'(firstA), 32'h0900);
`ifdef CONV_PAIR_MAC_RELU_EN
    checkOutput("neg_b", 32'(firstB), 32'h0000);
`else
    checkOutput("neg_b", 32'(firstB), 32'hF700);
`endif

    // Full sweep with centre-tap identity kernels
    for (int n = 0; n < NK; n++) rom[n] = {64'h0, 16'h0100, 64'h0};
    w1 = rand144();
    w1[79:64] = 16'h0123;
    applyStimulus(w1, '0, 1'b0, 0);
    checkOutput("centre_a", 32'(firstA), 32'h0123);
    checkOutput("centre_b", 32'(firstB), 32'h0123);

    // Saturation both ways
    for (int n = 0; n < NK; n++) rom[n] = (n % 2 == 0) ? {9{16'h7FFF}} : {9{16'h8000}};
    applyStimulus({9{16'h7FFF}}, '0, 1'b0, 0);
    checkOutput("sat_pos", 32'(firstA), 32'h7FFF);
`ifdef CONV_PAIR_MAC_RELU_EN
    checkOutput("sat_neg", 32'(firstB), 32'h0000);
`else
    checkOutput("sat_neg", 32'(firstB), 32'h8000);
`endif

    // Truncation toward -inf: sum of -1 shifts to -1
    for (int n = 0; n < NK; n++) rom[n] = {16'h0001, 128'h0};
    applyStimulus({16'hFFFF, 128'h0}, '0, 1'b0, 0);
`ifdef CONV_PAIR_MAC_RELU_EN
    checkOutput("trunc_a", 32'(firstA), 32'h0000);
`else
    checkOutput("trunc_a", 32'(firstA), 32'hFFFF);
`endif

    // Random windows and kernels
    for (int t = 0; t < 2; t++) begin
      for (int n = 0; n < NK; n++) rom[n] = rand144();
      applyStimulus(rand144(), '0, 1'b0, 0);
    end

    // Handshake held high: back-to-back windows, second one differs
    w1 = rand144();
    w2 = rand144();
    applyStimulus(w1, w2, 1'b1, 0);
    checkOutput("b2b_first_a", 32'(firstA), 32'(refDot(w2, rom[0])));

    // Reset mid-sweep, then a clean window from kernel 0
    applyStimulus(rand144(), '0, 1'b0, 10);
    applyStimulus(rand144(), '0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
